// File: rtl/put_in_order.sv
// put_in_order: restores the round-robin issue order of items that return
// out of order on n_inputs lanes.
// Each lane has one slot, made of a valid flag and a data register. A read
// pointer names the lane that must be emitted next. An item arriving on that
// lane bypasses its slot and is emitted on the following cycle.
//
// Ports:
//   clk        single clock; all state updates on its rising edge
//   rst        synchronous, active-high reset
//   up_vlds    per-lane valid; bit i qualifies up_data[i] for one cycle
//   up_data    per-lane data; lane i is up_data[i]
//   down_vld   registered output valid, one item per asserted cycle
//   down_data  registered output item; meaningful only while down_vld is 1
module put_in_order #(
  parameter int unsigned width    = 8,
  parameter int unsigned n_inputs = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [n_inputs-1:0]                up_vlds,
  input  logic [n_inputs-1:0][width-1:0]     up_data,
  output logic                               down_vld,
  output logic [width-1:0]                   down_data
);

  localparam int unsigned ptr_w = $clog2(n_inputs);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(n_inputs - 1);

  logic [ptr_w-1:0] rd_ptr;
  logic [n_inputs-1:0] slot_vld;
  logic [width-1:0] slot_data [n_inputs];

  logic cand_vld_c;
  logic [width-1:0] cand_data_c;

  // Next-in-order candidate: a live arrival on rd_ptr wins over the slot.
  always_comb begin
    cand_vld_c  = 1'b0;
    cand_data_c = '0;
    if (up_vlds[rd_ptr]) begin
      cand_vld_c  = 1'b1;
      cand_data_c = up_data[rd_ptr];
    end else if (slot_vld[rd_ptr]) begin
      cand_vld_c  = 1'b1;
      cand_data_c = slot_data[rd_ptr];
    end
  end

  // Control state: output register, read pointer and slot valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_vld  <= 1'b0;
      down_data <= '0;
      rd_ptr    <= '0;
      slot_vld  <= '0;
    end else begin
      down_vld <= cand_vld_c;
      if (cand_vld_c) begin
        down_data        <= cand_data_c;
        slot_vld[rd_ptr] <= 1'b0;
        rd_ptr           <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_w'(1);
      end
      // Lane rd_ptr never needs its slot: its arrival is consumed by bypass.
      for (int i = 0; i < int'(n_inputs); i++) begin
        if (up_vlds[i] && (ptr_w'(i) != rd_ptr)) begin
          slot_vld[i] <= 1'b1;
        end
      end
    end
  end

  // Slot data needs no reset; it is only read while its valid flag is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(n_inputs); i++) begin
      if (up_vlds[i] && (ptr_w'(i) != rd_ptr)) begin
        slot_data[i] <= up_data[i];
      end
    end
  end

endmodule

// File: tb/tb_put_in_order.sv
// Bench for put_in_order. Each scenario is a list of items in issue order,
// together with the cycle at which each one returns on lane (k mod N). The
// emission cycle of item k is max(arrival_k, emission_{k-1} + 1). From those
// cycles the bench builds per-cycle expectations. A single compare process
// checks the DUT against them after every clock edge.
module tb_put_in_order;

  localparam int unsigned W    = 8;
  localparam int unsigned N    = 10;
  localparam int          MAXI = 64;
  localparam int          MAXC = 512;
  localparam int          INF  = 100000;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        up_vlds;
  logic [N-1:0][W-1:0] up_data;
  logic                down_vld;
  logic [W-1:0]        down_data;

  always #5 clk = ~clk;

  put_in_order #(.width(W), .n_inputs(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vlds   (up_vlds),
    .up_data   (up_data),
    .down_vld  (down_vld),
    .down_data (down_data)
  );

  int         t_arr [MAXI];
  logic [W-1:0] d_arr [MAXI];
  int         e_arr [MAXI];
  int         nitems;
  logic       exp_vld  [MAXC];
  logic [W-1:0] exp_data [MAXC];

  int    cur_cyc;
  int    chk_mode;   // 0 idle, 1 scenario, 2 reset
  string scen;
  int    vectors;
  int    miscompares;

  // Compare process: runs just after every rising edge.
  always @(posedge clk) begin
    #1;
    if (chk_mode == 2) begin
      vectors++;
      if (down_vld !== 1'b0 || down_data !== '0) begin
        miscompares++;
        $display("FAIL %s reset: down_vld=%0b down_data=%02h, required 0/00",
                 scen, down_vld, down_data);
      end
    end else if (chk_mode == 1) begin
      vectors++;
      if (down_vld !== exp_vld[cur_cyc] ||
          (exp_vld[cur_cyc] && down_data !== exp_data[cur_cyc])) begin
        miscompares++;
        $display("FAIL %s cycle %0d: down_vld=%0b down_data=%02h, required %0b/%02h",
                 scen, cur_cyc, down_vld, down_data, exp_vld[cur_cyc],
                 exp_data[cur_cyc]);
      end
    end
  end

  // Item k+N must not return before item k has left its slot.
  // Returns the number of cycles the scenario needs.
  function automatic int build_model();
    int last;
    last = 0;
    for (int c = 0; c < MAXC; c++) begin
      exp_vld[c]  = 1'b0;
      exp_data[c] = '0;
    end
    for (int k = 0; k < nitems; k++) begin
      if (k >= int'(N) && e_arr[k-N] < INF && t_arr[k] < INF &&
          t_arr[k] <= e_arr[k-N])
        t_arr[k] = e_arr[k-N] + 1;
      if (k == 0) e_arr[k] = t_arr[k];
      else        e_arr[k] = (t_arr[k] > e_arr[k-1] + 1) ? t_arr[k] : e_arr[k-1] + 1;
      if (e_arr[k] >= INF) e_arr[k] = INF;
      if (e_arr[k] < MAXC) begin
        exp_vld[e_arr[k]]  = 1'b1;
        exp_data[e_arr[k]] = d_arr[k];
        if (e_arr[k] > last) last = e_arr[k];
      end
      if (t_arr[k] < MAXC && t_arr[k] > last) last = t_arr[k];
    end
    return (last + 4 > 6) ? last + 4 : 6;
  endfunction

  task automatic apply_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      up_vlds  = N'($urandom);
      for (int j = 0; j < int'(N); j++) up_data[j] = W'($urandom);
      chk_mode = 2;
    end
  endtask

  task automatic run_scenario(input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      rst     = 1'b0;
      up_vlds = '0;
      for (int j = 0; j < int'(N); j++) up_data[j] = W'($urandom);
      for (int k = 0; k < nitems; k++) begin
        if (t_arr[k] == c) begin
          up_vlds[k % N] = 1'b1;
          up_data[k % N] = d_arr[k];
        end
      end
      cur_cyc  = c;
      chk_mode = 1;
    end
    @(negedge clk);
    up_vlds  = '0;
    chk_mode = 0;
  endtask

  task automatic pin(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL pin %s: model gives %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    int len;
    int s;
    vectors     = 0;
    miscompares = 0;
    chk_mode    = 0;
    cur_cyc     = 0;
    rst         = 1'b1;
    up_vlds     = '0;
    up_data     = '0;
    scen        = "init";

    // In order: item i on lane i at cycle i.
    apply_reset(2);
    scen = "in_order";
    nitems = 10;
    for (int k = 0; k < 10; k++) begin
      t_arr[k] = k;
      d_arr[k] = W'(k);
    end
    len = build_model();
    pin("in_order e0", e_arr[0], 0);
    pin("in_order e9", e_arr[9], 9);
    run_scenario(len);

    // Reversed: lane 9 first, lane 0 last.
    apply_reset(2);
    scen = "reversed";
    nitems = 10;
    for (int k = 0; k < 10; k++) begin
      t_arr[k] = 9 - k;
      d_arr[k] = W'(k);
    end
    len = build_model();
    pin("reversed e0", e_arr[0], 9);
    pin("reversed e9", e_arr[9], 18);
    run_scenario(len);

    // Burst: lanes 1..9 together, lane 0 three cycles later.
    apply_reset(2);
    scen = "burst";
    nitems = 10;
    for (int k = 0; k < 10; k++) begin
      t_arr[k] = (k == 0) ? 3 : 0;
      d_arr[k] = W'(k);
    end
    len = build_model();
    pin("burst e0", e_arr[0], 3);
    pin("burst e9", e_arr[9], 12);
    run_scenario(len);

    // Extreme data values, with two wraps of the lane sequence.
    apply_reset(1);
    scen = "extremes";
    nitems = 20;
    for (int k = 0; k < 20; k++) begin
      t_arr[k] = k + ((k % 3 == 0) ? 2 : 0);
      d_arr[k] = (k % 2 == 0) ? 8'hff : 8'h00;
    end
    len = build_model();
    run_scenario(len);

    // Wrap-around: 30 counting items, then 20 random ones, 80% issue rate.
    apply_reset(2);
    scen = "wrap_random";
    nitems = 50;
    s = 0;
    for (int k = 0; k < 50; k++) begin
      while ($urandom_range(99, 0) >= 80) s++;
      t_arr[k] = s + int'($urandom_range(9, 0));
      d_arr[k] = (k < 30) ? W'(k) : W'($urandom);
      s++;
    end
    len = build_model();
    pin("wrap item 29 data", int'(exp_data[e_arr[29]]), 29);
    run_scenario(len);

    // Reset mid-stream: lanes 1..3 buffered, lane 0 never arrives.
    apply_reset(1);
    scen = "mid_reset_pre";
    nitems = 4;
    t_arr[0] = INF;
    for (int k = 1; k < 4; k++) begin
      t_arr[k] = 0;
      d_arr[k] = W'(8'h40 + k);
    end
    d_arr[0] = 8'h40;
    len = build_model();
    run_scenario(len);
    scen = "mid_reset";
    apply_reset(2);
    // Lanes 1..3 are refilled first; nothing may come out before lane 0.
    scen = "mid_reset_post";
    nitems = 4;
    for (int k = 0; k < 4; k++) begin
      t_arr[k] = (k == 0) ? 4 : 1;
      d_arr[k] = W'(8'h80 + k);
    end
    len = build_model();
    pin("post_reset e0", e_arr[0], 4);
    run_scenario(len);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
